axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter DATA_BITS, default AXI_DATA_BITS (32), data width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 16384, memory depth in words; power of two.
REQ-003 ACLK  in  1  clock; all logic on rising edge.
REQ-004 ARESETn  in  1  reset, asynchronous, active-low.
REQ-005 ARADDR  in  32  read burst byte address.
REQ-006 ARLEN  in  4  read beats minus one.
REQ-007 ARVALID  in  1  read address valid.
REQ-008 ARREADY  out  1  read address accepted.
REQ-009 RDATA  out  DATA_BITS  read beat data.
REQ-010 RRESP  out  2  read response, OKAY=0 or SLVERR=2.
REQ-011 RLAST  out  1  final read beat.
REQ-012 RVALID  out  1  read beat valid.
REQ-013 RREADY  in  1  master accepts read beat.
REQ-014 AWADDR  in  32  write burst byte address.
REQ-015 AWLEN  in  4  write beats minus one.
REQ-016 AWVALID  in  1  write address valid.
REQ-017 AWREADY  out  1  write address accepted.
REQ-018 WDATA  in  DATA_BITS  write beat data.
REQ-019 WSTRB  in  DATA_BITS/8  byte enables.
REQ-020 WLAST  in  1  master marks final write beat.
REQ-021 WVALID  in  1  write beat valid.
REQ-022 WREADY  out  1  write beat accepted.
REQ-023 BRESP  out  2  write response, OKAY or SLVERR.
REQ-024 BVALID  out  1  write response valid.
REQ-025 BREADY  in  1  master accepts write response.

Function
REQ-026 SHALL use FSM IDLE, RD, WR, WRESP; exactly one burst in flight.
REQ-027 SHALL assert ARREADY=1 in IDLE only; AWREADY = IDLE & !ARVALID, so read wins simultaneous AR/AW.
REQ-028 SHALL, on an AR handshake at cycle T, capture address/length, enter RD, and present beat 0 with RVALID=1 at T+2 (one-cycle SRAM read).
REQ-029 SHALL hold RDATA/RRESP/RLAST stable while RVALID & !RREADY; with RREADY held high, beats SHALL issue on consecutive cycles.
REQ-030 SHALL increment the address by 4 per beat (INCR only, ARADDR[1:0] ignored); RLAST=1 on beat ARLEN; after the RLAST handshake, return to IDLE.
REQ-031 SHALL, on an AW handshake, enter WR with WREADY=1; WREADY=0 outside WR (no early W acceptance).
REQ-032 SHALL write each W-handshake beat to SRAM byte-wise per WSTRB; WSTRB=0 writes nothing.
REQ-033 SHALL end WR after AWLEN+1 beats by count, then WRESP with BVALID=1 held until BREADY; BVALID deasserts the cycle after the handshake, IDLE follows.
REQ-034 SHALL set BRESP=SLVERR when WLAST disagrees with the beat count on any beat; the count still governs termination.
REQ-035 SHALL treat a beat with word index >= DEPTH_WORDS as out-of-range: reads return RDATA=0, RRESP=SLVERR; writes are dropped and force BRESP=SLVERR; no address wrap.
REQ-036 SHALL commit all write data before BVALID rises, so a following read returns the new data.

Reset
REQ-037 SHALL, on ARESETn low, go to IDLE with RVALID, RLAST, WREADY, BVALID = 0, RRESP/BRESP = OKAY, RDATA = 0, ARREADY=1; any burst in flight is abandoned with no R/B response; SRAM contents are not cleared.

Structure
REQ-038 SHALL place resp enum (OKAY, SLVERR) and FSM state enum in package AXI_define beside AXI_DATA_BITS.
REQ-039 SHALL instantiate one sub-module sram_sp (single-port, synchronous read, byte-write-enable); ports are never read and written in the same cycle.

Verification
REQ-040 Single write AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=0xF, then read ARADDR=0x10 -> RDATA=0xDEADBEEF, RRESP=OKAY, RLAST=1, RVALID at T+2.
REQ-041 Read burst ARLEN=3 at 0x0 with RREADY toggling 1,0,1,0 -> 4 beats in address order, data stable across stalls, RLAST only on 4th.
REQ-042 Write WSTRB=0x3, WDATA=0x11112222 over 0xAAAAAAAA -> read returns 0xAAAA2222.
REQ-043 ARVALID and AWVALID together in IDLE -> read served first, AWREADY=0 until IDLE again.
REQ-044 Write burst AWLEN=1 with WLAST=1 on beat 0 -> 2 beats accepted, BRESP=SLVERR; read at DEPTH_WORDS*4 -> RDATA=0, RRESP=SLVERR.
REQ-045 ARESETn pulsed low mid-read-burst -> RVALID=0 immediately, IDLE, ARREADY=1, prior SRAM data intact.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI definitions: bus width, response codes, slave FSM states.
package AXI_define;

    localparam int AXI_DATA_BITS = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WRESP
    } state_e;

endpackage

// File: rtl/axi_sram_slave_sram.sv
// Single-port SRAM, synchronous read, per-byte write enables.
module sram_sp #(
    parameter int DATA_BITS   = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   re,
    input  logic [DATA_BITS/8-1:0] we,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [DATA_BITS-1:0]   wdata,
    output logic [DATA_BITS-1:0]   rdata
);

    logic [DATA_BITS-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_BITS-1:0] rdata_q;

    // rdata_q holds its value between reads; the slave relies on that
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[addr];
        end
        for (int b = 0; b < DATA_BITS / 8; b++) begin
            if (we[b]) begin
                mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI burst slave in front of a single-port SRAM, one burst at a time.
module axi_sram_slave
    import AXI_define::*;
#(
    parameter int DATA_BITS   = AXI_DATA_BITS,
    parameter int DEPTH_WORDS = 16384
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [31:0]            ARADDR,
    input  logic [3:0]             ARLEN,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [DATA_BITS-1:0]   RDATA,
    output logic [1:0]             RRESP,
    output logic                   RLAST,
    output logic                   RVALID,
    input  logic                   RREADY,
    input  logic [31:0]            AWADDR,
    input  logic [3:0]             AWLEN,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [DATA_BITS-1:0]   WDATA,
    input  logic [DATA_BITS/8-1:0] WSTRB,
    input  logic                   WLAST,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int SW = DATA_BITS / 8;

    state_e               state_q, state_d;
    logic [30:0]          idx_q, idx_d;
    logic [3:0]           len_q, len_d;
    logic [4:0]           left_q, left_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic                 werr_q, werr_d;
    logic                 s1_v_q, s1_v_d;
    logic                 s1_oor_q, s1_oor_d;
    logic                 s1_last_q, s1_last_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    resp_e                rresp_q, rresp_d;
    logic                 rlast_q, rlast_d;
    resp_e                bresp_q, bresp_d;

    logic                 idx_oor;
    logic                 load_out;
    logic                 issue;
    logic                 beat_err;
    logic                 sram_re;
    logic [SW-1:0]        sram_we;
    logic [DATA_BITS-1:0] sram_rdata;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^{ARADDR[1:0], AWADDR[1:0]};

    // 31-bit word index so a burst near the top of the map never wraps
    assign idx_oor = (idx_q >= 31'(DEPTH_WORDS));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        left_d    = left_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        s1_v_d    = s1_v_q;
        s1_oor_d  = s1_oor_q;
        s1_last_d = s1_last_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        bresp_d   = bresp_q;
        load_out  = 1'b0;
        issue     = 1'b0;
        beat_err  = 1'b0;
        sram_re   = 1'b0;
        sram_we   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (ARVALID) begin
                    idx_d   = {1'b0, ARADDR[31:2]};
                    left_d  = {1'b0, ARLEN} + 5'd1;
                    state_d = ST_RD;
                end else if (AWVALID) begin
                    idx_d   = {1'b0, AWADDR[31:2]};
                    len_d   = AWLEN;
                    wcnt_d  = '0;
                    werr_d  = 1'b0;
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                // SRAM output is a holding stage ahead of the R register
                load_out = s1_v_q && (!rvalid_q || RREADY);
                issue    = (left_q != 5'd0) && (!s1_v_q || load_out);
                sram_re  = issue && !idx_oor;
                if (issue) begin
                    idx_d     = idx_q + 31'd1;
                    left_d    = left_q - 5'd1;
                    s1_oor_d  = idx_oor;
                    s1_last_d = (left_q == 5'd1);
                end
                s1_v_d = issue || (s1_v_q && !load_out);
                if (rvalid_q && RREADY) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end
                end
                if (load_out) begin
                    rvalid_d = 1'b1;
                    rdata_d  = s1_oor_q ? '0 : sram_rdata;
                    rresp_d  = s1_oor_q ? RESP_SLVERR : RESP_OKAY;
                    rlast_d  = s1_last_q;
                end
            end
            ST_WR: begin
                if (WVALID) begin
                    beat_err = idx_oor || (WLAST != (wcnt_q == len_q));
                    sram_we  = idx_oor ? '0 : WSTRB;
                    werr_d   = werr_q || beat_err;
                    idx_d    = idx_q + 31'd1;
                    wcnt_d   = wcnt_q + 4'd1;
                    if (wcnt_q == len_q) begin
                        bresp_d = (werr_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (BREADY) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            left_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_oor_q  <= 1'b0;
            s1_last_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            left_q    <= left_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            s1_v_q    <= s1_v_d;
            s1_oor_q  <= s1_oor_d;
            s1_last_q <= s1_last_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            bresp_q   <= bresp_d;
        end
    end

    sram_sp #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_BITS  (AW)
    ) u_sram (
        .clk  (ACLK),
        .re   (sram_re),
        .we   (sram_we),
        .addr (idx_q[AW-1:0]),
        .wdata(WDATA),
        .rdata(sram_rdata)
    );

    assign ARREADY = (state_q == ST_IDLE);
    assign AWREADY = (state_q == ST_IDLE) && !ARVALID;
    assign WREADY  = (state_q == ST_WR);
    assign BVALID  = (state_q == ST_WRESP);
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
    assign BRESP   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: reference memory plus R/B queues.
module tb_axi_sram_slave;
    import AXI_define::*;

    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [31:0]   ARADDR = '0;
    logic [3:0]    ARLEN = '0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic [31:0]   AWADDR = '0;
    logic [3:0]    AWLEN = '0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [DW-1:0] WDATA = '0;
    logic [3:0]    WSTRB = '0;
    logic          WLAST = 1'b0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY = 1'b0;

    always #5 ACLK = ~ACLK;

    axi_sram_slave #(
        .DATA_BITS  (DW),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] mdl [DEPTH];
    int          n_chk = 0;
    int          n_err = 0;
    logic        aw_pending = 1'b0;
    logic        aw_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len,
                             input logic [31:0] base, input logic [3:0] strb,
                             input logic [15:0] wl);
        int          budget;
        logic        hs;
        logic        err;
        logic [31:0] idx;
        logic [1:0]  b;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            idx = (addr >> 2) + 32'(i);
            if (idx >= 32'(DEPTH)) err = 1'b1;
            if (wl[i] != (i == len)) err = 1'b1;
        end
        bq.push_back(err ? 2'b10 : 2'b00);
        AWADDR  = addr;
        AWLEN   = len[3:0];
        AWVALID = 1'b1;
        budget  = 0;
        do begin
            hs = AWREADY;
            tick();
            budget++;
        end while (!hs && budget < 200);
        AWVALID    = 1'b0;
        aw_pending = 1'b0;
        chk("aw_hs", hs, 1);
        for (int i = 0; i <= len; i++) begin
            idx    = (addr >> 2) + 32'(i);
            WDATA  = base + 32'(i);
            WSTRB  = strb;
            WLAST  = wl[i];
            WVALID = 1'b1;
            budget = 0;
            do begin
                hs = WREADY;
                tick();
                budget++;
            end while (!hs && budget < 200);
            chk("w_hs", hs, 1);
            if (idx < 32'(DEPTH)) begin
                for (int k = 0; k < 4; k++)
                    if (strb[k]) mdl[idx][k*8 +: 8] = WDATA[k*8 +: 8];
            end
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        chk("wready_off", WREADY, 0);
        chk("bvalid_rise", BVALID, 1);
        tick();
        chk("bvalid_hold", BVALID, 1);
        BREADY = 1'b1;
        budget = 0;
        hs     = 1'b0;
        while (!hs && budget < 200) begin
            hs = BVALID;
            if (hs) begin
                b = bq.pop_front();
                chk("bresp", BRESP, b);
            end
            tick();
            budget++;
        end
        chk("b_hs", hs, 1);
        chk("bvalid_drop", BVALID, 0);
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len,
                            input logic [7:0] pat, input bit lat,
                            input bit b2b, input int stop_after);
        int          budget;
        int          got;
        int          cyc;
        logic        hs;
        logic        stalled;
        logic [35:0] held;
        logic [31:0] idx;
        rbeat_t      e;
        for (int i = 0; i <= len; i++) begin
            idx    = (addr >> 2) + 32'(i);
            e.data = (idx < 32'(DEPTH)) ? mdl[idx] : 32'h0;
            e.resp = (idx < 32'(DEPTH)) ? 2'b00 : 2'b10;
            e.last = (i == len);
            rq.push_back(e);
        end
        ARADDR  = addr;
        ARLEN   = len[3:0];
        ARVALID = 1'b1;
        #1;
        if (aw_pending) begin
            chk("ar_wins_awready", AWREADY, 0);
            chk("ar_wins_arready", ARREADY, 1);
        end
        budget = 0;
        do begin
            hs = ARREADY;
            tick();
            budget++;
        end while (!hs && budget < 200);
        ARVALID = 1'b0;
        chk("ar_hs", hs, 1);
        if (lat) begin
            tick();
            chk("rvalid_t1", RVALID, 0);
            tick();
            chk("rvalid_t2", RVALID, 1);
        end
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        budget  = 0;
        while (got <= len && got != stop_after && budget < 400) begin
            RREADY = pat[cyc % 8];
            if (aw_pending) aw_seen = aw_seen | AWREADY;
            if (stalled)
                chk("r_stable", {RVALID, RLAST, RRESP, RDATA}, held);
            if (b2b && got > 0)
                chk("r_b2b", RVALID, 1);
            if (RVALID && RREADY) begin
                e = rq.pop_front();
                chk("rdata", RDATA, e.data);
                chk("rresp", RRESP, e.resp);
                chk("rlast", RLAST, e.last);
                got++;
                stalled = 1'b0;
            end else if (RVALID) begin
                stalled = 1'b1;
                held    = {RVALID, RLAST, RRESP, RDATA};
            end
            tick();
            cyc++;
            budget++;
        end
        RREADY = 1'b0;
        chk("r_beats", got, (stop_after < 0) ? len + 1 : stop_after);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          l;
        repeat (3) tick();
        chk("rst_rvalid", RVALID, 0);
        chk("rst_arready", ARREADY, 1);
        ARESETn = 1'b1;
        tick();
        chk("idle_arready", ARREADY, 1);
        chk("idle_awready", AWREADY, 1);
        chk("idle_rvalid", RVALID, 0);
        chk("idle_rlast", RLAST, 0);
        chk("idle_rdata", RDATA, 0);
        chk("idle_rresp", RRESP, 0);
        chk("idle_wready", WREADY, 0);
        chk("idle_bvalid", BVALID, 0);
        chk("idle_bresp", BRESP, 0);

        for (int i = 0; i < DEPTH / 16; i++)
            axi_write(32'(i * 64), 15, 32'hC000_0000 + 32'(i << 8), 4'hF,
                      16'h8000);

        axi_write(32'h10, 0, 32'hDEADBEEF, 4'hF, 16'h1);
        axi_read(32'h10, 0, 8'hFF, 1'b1, 1'b0, -1);
        chk("single_word", mdl[4], 32'hDEADBEEF);

        axi_write(32'h0, 3, 32'h1000_0000, 4'hF, 16'h8);
        axi_read(32'h0, 3, 8'h55, 1'b0, 1'b0, -1);
        axi_read(32'h0, 7, 8'hFF, 1'b1, 1'b1, -1);

        axi_write(32'h20, 0, 32'hAAAAAAAA, 4'hF, 16'h1);
        axi_write(32'h20, 0, 32'h11112222, 4'h3, 16'h1);
        axi_write(32'h20, 0, 32'h99999999, 4'h0, 16'h1);
        axi_read(32'h20, 0, 8'hFF, 1'b0, 1'b0, -1);
        chk("strobe_model", mdl[8], 32'hAAAA2222);

        AWADDR     = 32'h30;
        AWLEN      = 4'd0;
        AWVALID    = 1'b1;
        aw_pending = 1'b1;
        aw_seen    = 1'b0;
        axi_read(32'h20, 1, 8'h33, 1'b0, 1'b0, -1);
        chk("aw_blocked", aw_seen, 0);
        axi_write(32'h30, 0, 32'h5555AAAA, 4'hF, 16'h1);
        axi_read(32'h30, 0, 8'hFF, 1'b0, 1'b0, -1);

        axi_write(32'h40, 1, 32'h7700_0000, 4'hF, 16'h3);
        axi_read(32'h40, 1, 8'hFF, 1'b0, 1'b1, -1);
        axi_write(32'(DEPTH * 4 - 4), 1, 32'h4242_0000, 4'hF, 16'h2);
        axi_read(32'(DEPTH * 4 - 4), 1, 8'hFF, 1'b0, 1'b0, -1);
        axi_read(32'(DEPTH * 4), 0, 8'hFF, 1'b1, 1'b0, -1);
        axi_read(32'h0, 0, 8'hFF, 1'b0, 1'b0, -1);

        for (int n = 0; n < 6; n++) begin
            a = 32'($urandom_range(0, DEPTH - 17)) << 2;
            l = int'($urandom_range(0, 15));
            axi_write(a, l, $urandom, 4'($urandom), 16'(1 << l));
            axi_read(a, l, 8'($urandom) | 8'h01, 1'b0, 1'b0, -1);
        end

        axi_read(32'h0, 7, 8'hFF, 1'b0, 1'b0, 2);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_rvalid", RVALID, 0);
        chk("mid_rst_rlast", RLAST, 0);
        chk("mid_rst_rdata", RDATA, 0);
        chk("mid_rst_arready", ARREADY, 1);
        rq.delete();
        tick();
        tick();
        ARESETn = 1'b1;
        tick();
        chk("post_rst_rvalid", RVALID, 0);
        chk("post_rst_arready", ARREADY, 1);
        axi_read(32'h0, 15, 8'hFF, 1'b1, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
